neuron_mac_sequencer: RTL and testbench

//  Consumer of one weight BRAM plus one input-activation BRAM: walks both address spaces,

---
 rtl/neuron_mac_sequencer.sv | 114 +++++++++++
 tb/tb_neuron_mac_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// One-neuron MAC sequencer: streams N_INPUTS weight/input pairs from two BRAMs, adds a Q8.8 bias,
// rounds, saturates and emits one result. Optional macro NEURON_RELU_EN clamps negative results to 0.
module neuron_mac_sequencer #(
   parameter int N_INPUTS  = 28,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   output logic [ADDR_W-1:0] w_addr,
   output logic              w_en,
   input  logic [DATA_W-1:0] w_do,
   output logic [ADDR_W-1:0] x_addr,
   output logic              x_en,
   input  logic [DATA_W-1:0] x_do,
   output logic              busy,
   output logic [DATA_W-1:0] y,
   output logic              y_valid
);

   // state | meaning
   // IDLE  | waiting for start; bias loaded into acc on acceptance
   // RUN   | addresses 0..N-1 issued, one product accumulated per cycle
   // DRAIN | last address already issued; accumulate its product, drop enables
   // OUT   | round, saturate, register result and pulse y_valid
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

   localparam logic [ADDR_W-1:0] PEN_ADDR = ADDR_W'(N_INPUTS - 2);
   localparam logic signed [ACC_W-1:0] RND_HALF =
      {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] Y_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   bias_ext;
   logic signed [ACC_W-1:0]   acc_rnd;
   logic signed [ACC_W-1:0]   acc_shr;
   logic [DATA_W-1:0]         y_act;

   assign prod     = $signed(w_do) * $signed(x_do);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
   assign acc_rnd  = acc + RND_HALF;
   assign acc_shr  = acc_rnd >>> FRAC_BITS;

   always_comb begin
      y_act = acc_shr[DATA_W-1:0];
      if (acc_shr > Y_MAX)
         y_act = {1'b0, {(DATA_W-1){1'b1}}};
      else if (acc_shr < Y_MIN)
         y_act = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef NEURON_RELU_EN
      if (y_act[DATA_W-1])
         y_act = '0;
`endif
   end

   // Both BRAMs walk the same address space, so they share one address/enable register.
   assign x_addr = w_addr;
   assign x_en   = w_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         w_addr  <= '0;
         w_en    <= 1'b0;
         acc     <= '0;
         busy    <= 1'b0;
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= bias_ext;
                  w_addr <= '0;
                  w_en   <= 1'b1;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc + prod_ext;
               w_addr <= w_addr + ADDR_W'(1);
               if (w_addr == PEN_ADDR)
                  state <= DRAIN;
            end
            DRAIN: begin
               acc   <= acc + prod_ext;
               w_en  <= 1'b0;
               state <= OUT;
            end
            OUT: begin
               y       <= y_act;
               y_valid <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer: BRAM models, an arithmetic reference model of the
// neuron result and cycle timing, a per-cycle compare process, and literal checks of known cases.
module tb_neuron_mac_sequencer;
   localparam int N = 28;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [15:0] bias;
   logic [4:0]  w_addr, x_addr;
   logic        w_en, x_en, busy, y_valid;
   logic [15:0] w_do = '0, x_do = '0, y;

   logic [15:0] w_mem [N];
   logic [15:0] x_mem [N];

   int checks = 0, errors = 0;
   bit chk_en = 1'b0;

   // reference model state
   bit          busy_m = 1'b0, yv_m = 1'b0;
   int          cnt = 0;
   logic [15:0] y_m = '0, y_pend = '0;

   always #5 clk = ~clk;

   neuron_mac_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
      .w_addr(w_addr), .w_en(w_en), .w_do(w_do),
      .x_addr(x_addr), .x_en(x_en), .x_do(x_do),
      .busy(busy), .y(y), .y_valid(y_valid)
   );

   always @(negedge clk) begin
      if (w_en) w_do <= w_mem[w_addr];
      if (x_en) x_do <= x_mem[x_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_y(input logic [15:0] b);
      longint s;
      s = longint'($signed(b)) * 256;
      for (int i = 0; i < N; i++)
         s += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
      s = (s + 128) >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`ifdef NEURON_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[15:0];
   endfunction

   // Result appears N+1 edges after acceptance; enables cover the N address cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         busy_m = 1'b0; cnt = 0; yv_m = 1'b0; y_m = '0;
      end else begin
         yv_m = 1'b0;
         if (busy_m) begin
            cnt++;
            if (cnt == N + 1) begin
               busy_m = 1'b0; y_m = y_pend; yv_m = 1'b1;
            end
         end else if (start) begin
            busy_m = 1'b1; cnt = 0; y_pend = ref_y(bias);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_en;
         exp_en = busy_m && (cnt < N);
         chk("w_en", {31'd0, w_en}, {31'd0, exp_en});
         chk("x_en", {31'd0, x_en}, {31'd0, exp_en});
         chk("busy", {31'd0, busy}, {31'd0, busy_m});
         chk("y_valid", {31'd0, y_valid}, {31'd0, yv_m});
         chk("y", {16'd0, y}, {16'd0, y_m});
         if (exp_en) begin
            chk("w_addr", {27'd0, w_addr}, cnt);
            chk("x_addr", {27'd0, x_addr}, cnt);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
      for (int i = 0; i < N; i++) begin
         w_mem[i] = wv; x_mem[i] = xv;
      end
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = 0;
      while (!y_valid && lat < 60) begin
         cyc(1); lat++;
      end
      if (lat >= 60) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic run_one(input logic [15:0] b, output logic [15:0] yv, output int lat);
      bias = b; start = 1'b1; cyc(1); start = 1'b0;
      wait_done("run_one", lat);
      yv = y;
   endtask

   initial begin
      logic [15:0] yr;
      int lat, pulses;
      rst_n = 1'b0; start = 1'b0; bias = '0;
      fill(16'h0000, 16'h0000);
      cyc(2);
      chk_en = 1'b1;
      chk("rst_w_en", {31'd0, w_en}, 32'd0);
      chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
      chk("rst_y", {16'd0, y}, 32'd0);
      rst_n = 1'b1;
      cyc(2);

      fill(16'h0100, 16'h0100);
      run_one(16'h0000, yr, lat);
      chk("t1_y", {16'd0, yr}, 32'h1C00);
      chk("t1_latency", lat, 29);
      cyc(2);

      fill(16'h7FFF, 16'h7FFF);
      run_one(16'h0000, yr, lat);
      chk("t2_pos_sat", {16'd0, yr}, 32'h7FFF);
      cyc(1);
      fill(16'h7FFF, 16'h8000);
      run_one(16'h0000, yr, lat);
`ifdef NEURON_RELU_EN
      chk("t2_neg_sat", {16'd0, yr}, 32'h0000);
`else
      chk("t2_neg_sat", {16'd0, yr}, 32'h8000);
`endif
      cyc(1);

      fill(16'h0000, 16'h0000);
      w_mem[0] = 16'h0001; x_mem[0] = 16'h0080;
      run_one(16'h0000, yr, lat);
      chk("t3_round_up", {16'd0, yr}, 32'h0001);
      cyc(1);
      x_mem[0] = 16'h007F;
      run_one(16'h0000, yr, lat);
      chk("t3_round_down", {16'd0, yr}, 32'h0000);
      cyc(1);

      w_mem[0] = 16'hFF00; x_mem[0] = 16'h0100;
      run_one(16'h0000, yr, lat);
`ifdef NEURON_RELU_EN
      chk("t4_minus_one", {16'd0, yr}, 32'h0000);
`else
      chk("t4_minus_one", {16'd0, yr}, 32'hFF00);
`endif
      cyc(1);

      // abort mid-run
      fill(16'h0100, 16'h0100);
      bias = 16'h0000; start = 1'b1; cyc(1); start = 1'b0;
      cyc(9);
      rst_n = 1'b0; cyc(1);
      chk("t5_w_en_after_rst", {31'd0, w_en}, 32'd0);
      chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (y_valid) pulses++;
         cyc(1);
      end
      chk("t5_no_y_valid", pulses, 0);
      run_one(16'h0000, yr, lat);
      chk("t5_rerun_y", {16'd0, yr}, 32'h1C00);
      cyc(1);

      // ignored starts, then a start in the y_valid cycle
      for (int i = 0; i < N; i++) begin
         w_mem[i] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
         x_mem[i] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
      end
      bias = 16'h0180; start = 1'b1; cyc(1); start = 1'b0;
      pulses = 0;
      for (int c = 1; c < 27; c++) begin
         start = (c == 5 || c == 20);
         bias = 16'($urandom);
         cyc(1);
         if (y_valid) pulses++;
      end
      start = 1'b0;
      wait_done("t6_first", lat);
      chk("t6_early_pulses", pulses, 0);
      bias = 16'hFF80; start = 1'b1; cyc(1); start = 1'b0;
      wait_done("t6_second", lat);
      chk("t6_back_to_back_latency", lat, 29);
      cyc(2);

      // randomized runs
      for (int it = 0; it < 24; it++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         for (int i = 0; i < N; i++) begin
            case (mode)
               0: begin w_mem[i] = 16'($urandom); x_mem[i] = 16'($urandom); end
               1: begin
                  w_mem[i] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
                  x_mem[i] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
               end
               default: begin
                  w_mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
                  x_mem[i] = 16'($urandom_range(0, 16'h00FF)) - 16'h0080;
               end
            endcase
         end
         bias = 16'($urandom); start = 1'b1; cyc(1); start = 1'b0;
         for (int c = 1; c < 27; c++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) bias = 16'($urandom);
            cyc(1);
         end
         start = 1'b0;
         wait_done("rand", lat);
         cyc(1 + int'($urandom_range(0, 2)));
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
